// File: rtl/ram_byte_wr_sequencer.sv
// Round-robin write sequencer: expands a granted base/word request into single-byte
// writes at base+1.. on a shared en/wen/addr/din bus. WR_SEQ_FULL_WORD_EN adds a 4th byte.
module ram_byte_wr_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int GAP_CYCLES = 0,
`ifdef WR_SEQ_FULL_WORD_EN
  localparam int WORD_W = 32
`else
  localparam int WORD_W = 24
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_base,
  input  logic [WORD_W-1:0]     req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_base,
  input  logic [WORD_W-1:0]     req1_data,
  output logic                  en,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  done,
  output logic                  done_id
);

  localparam int         NUM_BYTES = WORD_W / 8;
  localparam logic [1:0] LAST_IDX  = 2'(NUM_BYTES - 1);
  localparam logic [3:0] GAP_LOAD  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           word;
  } req_t;

  state_t     state, state_nx;
  req_t       cur;
  logic [1:0] byte_idx;
  logic [3:0] gap_cnt;
  logic       last_grant;
  logic       served;
  logic       idle;
  logic       last_byte;
  logic [7:0] cur_byte;

  // A lone requester always wins; on contention the one not granted last wins.
  assign idle       = (state == IDLE);
  assign req0_ready = idle && req0_valid && (!req1_valid || last_grant);
  assign req1_ready = idle && req1_valid && (!req0_valid || !last_grant);
  assign busy       = !idle;
  assign wen        = en;
  assign last_byte  = (byte_idx == LAST_IDX);
  assign cur_byte   = cur.word[8*byte_idx +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req0_ready || req1_ready) state_nx = WRITE;
      WRITE: begin
        if (last_byte)           state_nx = DONE;
        else if (GAP_CYCLES > 0) state_nx = GAP;
        else                     state_nx = WRITE;
      end
      GAP:     if (gap_cnt == 4'd0) state_nx = WRITE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= '0;
      byte_idx   <= 2'd0;
      gap_cnt    <= 4'd0;
      last_grant <= 1'b1;
      served     <= 1'b0;
      en         <= 1'b0;
      addr       <= '0;
      din        <= '0;
      done       <= 1'b0;
      done_id    <= 1'b0;
    end else begin
      en   <= (state == WRITE);
      done <= (state == DONE);
      if (state == WRITE) begin
        addr <= cur.base + ADDR_WIDTH'(byte_idx) + ADDR_WIDTH'(1);
        din  <= DATA_WIDTH'(cur_byte);
      end
      if (state == DONE) done_id <= served;
      case (state)
        IDLE: begin
          byte_idx <= 2'd0;
          if (req0_ready) begin
            cur        <= {req0_base, 32'(req0_data)};
            last_grant <= 1'b0;
            served     <= 1'b0;
          end else if (req1_ready) begin
            cur        <= {req1_base, 32'(req1_data)};
            last_grant <= 1'b1;
            served     <= 1'b1;
          end
        end
        WRITE: begin
          if (!last_byte) begin
            if (GAP_CYCLES == 0) byte_idx <= byte_idx + 2'd1;
            else                 gap_cnt  <= GAP_LOAD;
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) byte_idx <= byte_idx + 2'd1;
          else                 gap_cnt  <= gap_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ram_byte_wr_sequencer.md
Name: ram_byte_wr_sequencer

Overview:
- Shared-bus write sequencer for byte-addressed register banks whose data bytes sit at base+1..base+3.
- Arbitrates two requesters, each presenting a base address and a 24-bit value, using round-robin.
- Expands the granted request into consecutive single-byte writes on one en/wen/addr/din bus.
- Sits between the host-pipe decode / local control FSMs and the register banks hanging off that bus.

Parameters:
- ADDR_WIDTH, 8, width of base addresses and the addr output.
- DATA_WIDTH, 32, width of the din output; bytes are driven on din[7:0] and the upper bits are 0.
- GAP_CYCLES, 0, idle cycles (en=0) inserted between consecutive byte writes; legal range 0..15.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has a pending word
- req0_ready  output  1  requester 0 accepted this cycle (combinational)
- req0_base  input  ADDR_WIDTH  requester 0 bank base address
- req0_data  input  24 (32 with WR_SEQ_FULL_WORD_EN)  requester 0 word
- req1_valid, req1_ready, req1_base, req1_data  same as requester 0
- en  output  1  bus enable, registered
- wen  output  1  bus write enable, registered; always equal to en
- addr  output  ADDR_WIDTH  bus address, registered
- din  output  DATA_WIDTH  bus data, registered
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse after the last byte write
- done_id  output  1  requester served by the current done pulse

Behaviour:
- Reset (asynchronous, clk: rising edge; rst_n: asynchronous, active-low) forces: en, wen, addr, din, done, done_id = 0; state = IDLE; last_grant = 1 (so req0 wins first).
- Reset asserted mid-sequence aborts immediately. Remaining bytes are dropped and no done pulse is issued.
- States: IDLE, WRITE, GAP, DONE.
- IDLE, grant rules:
  - reqN_ready = IDLE && reqN_valid && (the other request is not valid || last_grant != N).
  - A single valid requester always wins.
  - If both are valid, the requester that was not granted last wins.
  - Handshake is valid && ready at a rising edge. On acceptance: latch base/data, set last_grant = N, go to WRITE with byte_idx = 0.
  - Requesters hold valid and payload stable until ready is seen.
  - Both ready outputs are low in every state except IDLE.
- WRITE: drives en = wen = 1, addr = base + 1 + byte_idx (mod 2^ADDR_WIDTH, wraps silently), din = {0, data[8*byte_idx+7 : 8*byte_idx]}.
  - Not the last byte: go to GAP if GAP_CYCLES > 0, otherwise stay in WRITE with byte_idx + 1.
  - Last byte (idx 2): go to DONE.
- GAP: en = wen = 0; addr and din hold their last values. After GAP_CYCLES cycles, return to WRITE with byte_idx + 1.
- DONE: en = 0, done = 1 for exactly one cycle, done_id = served requester; then go to IDLE.
- Timing for a handshake at edge T (each "T+k" is a register-output cycle):
  - Byte writes visible in cycles T+1, T+2+G, T+3+2G, where G = GAP_CYCLES.
  - done in cycle T+4+2G.
  - Earliest next acceptance at edge T+5+2G.
- en is never high for more than one cycle per byte and never overlaps done.

Optional Feature:
- Macro: WR_SEQ_FULL_WORD_EN.
- Defined:
  - reqN_data is 32 bits.
  - A fourth byte write goes to base+4 with data[31:24].
  - done moves out by 1+G cycles.
- Undefined:
  - 24-bit data, three bytes only.
  - Address base+4 is never driven.

Test Plan:
- req0 base=0x10, data=0xA1B2C3, G=0, req0 valid alone -> ready at edge T. Writes (0x11,0xC3), (0x12,0xB2), (0x13,0xA1) in T+1..T+3. done=1 with done_id=0 at T+4. busy low at T+5.
- req0 and req1 both held valid from reset, with distinct bases -> grants in order 0,1,0,1. Each done_id matches the requester. Transactions start 5 cycles apart.
- G=2, req1 base=0x20, data=0x010203 -> en high only in T+1, T+4, T+7, at addresses 0x21, 0x22, 0x23. done at T+8. addr and din hold steady during gaps.
- Base=0xFE with ADDR_WIDTH=8 -> addresses 0xFF, 0x00, 0x01. No error and no stall.
- rst_n pulled low after the first byte of a sequence -> all outputs 0 asynchronously. No further en, no done. The next request is served normally, with req0 priority restored.
- WR_SEQ_FULL_WORD_EN defined, data=0xDEADBEEF, base=0x40 -> four writes 0xEF, 0xBE, 0xAD, 0xDE at 0x41..0x44. done at T+5.
